// File: rtl/uart_cfg_pkg.sv
// Shared types and constants for the UART configuration arbiter.
// The address map and BAUD reset value are shared with the register file.
package uart_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    HOLD,
    BAUD_WAIT,
    RSP
  } cfg_state_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_OOB     = 2'd1,
    ERR_TIMEOUT = 2'd2
  } rsp_err_e;

  localparam int unsigned ADDR_CTRL   = 0;
  localparam int unsigned ADDR_BAUD   = 1;
  localparam int unsigned ADDR_STATUS = 2;

  localparam int unsigned BAUD_RESET  = 9600;

endpackage

// File: rtl/uart_cfg_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: combinational one-hot grant while enabled,
// pointer moves to the loser of the last completed transaction.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       last,
  output logic [1:0] gnt
);

  logic rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (update) begin
      rr_ptr <= ~last;
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (&req) begin
        gnt = rr_ptr ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/uart_cfg_arbiter.sv
// Arbitrates two config masters onto the UART register file, one transaction at a time,
// deferring BAUD writes while the UART is busy and waiting for the update_ok commit.
module uart_cfg_arbiter
  import uart_cfg_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 3,
  parameter int N_REG        = 4,
  parameter int BAUD_ADDR    = int'(ADDR_BAUD),
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              gnt,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_err,
  output logic                    ctrl_busy,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [ADDR_WIDTH-1:0]   rd_addr_a,
  input  logic [DATA_WIDTH-1:0]   rd_data_a,
  input  logic                    uart_busy,
  input  logic                    update_ok
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]         CNT_MAX   = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0]         HOLD_LAST = CW'(TIMEOUT_CYC - 1);
  // BAUD_WAIT starts one cycle after wr_en, so the response lands TIMEOUT_CYC cycles after it.
  localparam logic [CW-1:0]         WAIT_LAST = CW'(TIMEOUT_CYC - 2);
  localparam logic [CW-1:0]         RD_LAST   = CW'(READ_LATENCY);
  localparam logic [ADDR_WIDTH-1:0] BAUD_A    = ADDR_WIDTH'(BAUD_ADDR);
  localparam logic [ADDR_WIDTH:0]   N_REG_L   = (ADDR_WIDTH + 1)'(N_REG);

  cfg_state_e              state, state_n;
  rsp_err_e                err_n;
  logic [CW-1:0]           cnt;
  logic                    winner;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [DATA_WIDTH-1:0]   cur_wdata;

  logic                    sel, sel_we, take, rsp_id_n;
  logic [ADDR_WIDTH-1:0]   sel_addr, op_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata, op_wdata;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     ((state == IDLE) && !rst),
    .req    (req),
    .update (state == RSP),
    .last   (winner),
    .gnt    (gnt)
  );

  assign sel       = gnt[1];
  assign sel_we    = req_we[sel];
  assign sel_addr  = sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
  assign sel_wdata = sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
  assign take      = (state == IDLE) && (|gnt);
  assign op_addr   = take ? sel_addr : cur_addr;
  assign op_wdata  = take ? sel_wdata : cur_wdata;
  assign rsp_id_n  = (state == IDLE) ? sel : winner;

  always_comb begin
    state_n = state;
    err_n   = ERR_OK;
    case (state)
      IDLE: begin
        if (|gnt) begin
          if ({1'b0, sel_addr} >= N_REG_L) begin
            state_n = RSP;
            err_n   = ERR_OOB;
          end else if (!sel_we) begin
            state_n = RD;
          end else if ((sel_addr == BAUD_A) && uart_busy) begin
            state_n = HOLD;
          end else begin
            state_n = WR;
          end
        end
      end
      RD:   if (cnt == RD_LAST) state_n = RSP;
      WR:   state_n = (cur_addr == BAUD_A) ? BAUD_WAIT : RSP;
      HOLD: begin
        if (!uart_busy) begin
          state_n = WR;
        end else if (cnt == HOLD_LAST) begin
          state_n = RSP;
          err_n   = ERR_TIMEOUT;
        end
      end
      BAUD_WAIT: begin
        if (update_ok) begin
          state_n = RSP;
        end else if (cnt == WAIT_LAST) begin
          state_n = RSP;
          err_n   = ERR_TIMEOUT;
        end
      end
      RSP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      winner    <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_addr_a <= '0;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
      rsp_err   <= 2'b00;
      ctrl_busy <= 1'b0;
    end else begin
      state     <= state_n;
      ctrl_busy <= (state_n != IDLE);
      wr_en     <= (state_n == WR);
      // Every state entry restarts the counter; it saturates rather than wraps.
      cnt       <= (state_n != state) ? '0 : ((cnt == CNT_MAX) ? cnt : cnt + 1'b1);
      if (take) begin
        winner    <= sel;
        cur_addr  <= sel_addr;
        cur_wdata <= sel_wdata;
      end
      if (state_n == WR) begin
        wr_addr <= op_addr;
        wr_data <= op_wdata;
      end
      if (state_n == RD) begin
        rd_addr_a <= op_addr;
      end
      rsp_valid <= 2'b00;
      if (state_n == RSP) begin
        rsp_valid <= rsp_id_n ? 2'b10 : 2'b01;
        rsp_err   <= err_n;
        rsp_rdata <= (state == RD) ? rd_data_a : '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cfg_arbiter.sv
// Directed bench for uart_cfg_arbiter with a register-file model and a response/write scoreboard.
module tb_uart_cfg_arbiter;
  import uart_cfg_pkg::*;

  localparam int W = 48;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  req_we = 2'b00;
  logic [5:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  gnt, rsp_valid, rsp_err;
  logic [15:0] rsp_rdata, wr_data, rd_data_a;
  logic        ctrl_busy, wr_en;
  logic [2:0]  wr_addr, rd_addr_a;
  logic        uart_busy = 1'b0;
  logic        update_ok = 1'b0;

  logic [15:0] mem [8];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          wr_cnt = 0;
  logic [W-1:0] exp_rsp_q[$];
  logic [W-1:0] exp_wr_q[$];

  uart_cfg_arbiter #(.TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ctrl_busy (ctrl_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .uart_busy (uart_busy),
    .update_ok (update_ok)
  );

  // Clock, cycle count and a one-cycle-latency register file.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_a <= mem[rd_addr_a];
  end

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    mem[ADDR_BAUD]   = 16'(BAUD_RESET);
    mem[ADDR_STATUS] = 16'h00A5;
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] rsp_vec(input int c, input int id, input logic [1:0] err,
                                           input logic [15:0] d);
    logic [15:0] c16;
    c16 = c[15:0];
    return {12'b0, c16, (id == 1) ? 2'b10 : 2'b01, err, d};
  endfunction

  function automatic logic [W-1:0] wr_vec(input int c, input logic [2:0] a, input logic [15:0] d);
    logic [15:0] c16;
    c16 = c[15:0];
    return {13'b0, c16, a, d};
  endfunction

  // Scoreboard monitor: every response and every write pulse must match the head of its queue.
  always @(negedge clk) begin
    if (rsp_valid != 2'b00) begin
      if (exp_rsp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got valid=%b err=%0d rdata=%h at cycle %0d, none required",
                 rsp_valid, rsp_err, rsp_rdata, cyc);
      end else begin
        check("rsp", {12'b0, cyc[15:0], rsp_valid, rsp_err, rsp_rdata}, exp_rsp_q.pop_front());
      end
    end
    if (wr_en === 1'b1) begin
      wr_cnt++;
      if (exp_wr_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL wr_unexpected: got wr_en addr=%0d data=%h at cycle %0d, none required",
                 wr_addr, wr_data, cyc);
      end else begin
        check("wr", {13'b0, cyc[15:0], wr_addr, wr_data}, exp_wr_q.pop_front());
      end
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    for (int i = 0; i < 1000 && cyc < n; i++) step();
  endtask

  task automatic issue(input int id, input logic we, input logic [2:0] addr,
                       input logic [15:0] wdata, output int gcyc);
    bit got = 1'b0;
    gcyc = -1000;
    req_we[id] = we;
    req_addr[id*3 +: 3] = addr;
    req_wdata[id*16 +: 16] = wdata;
    req[id] = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (gnt[id]) begin
        got = 1'b1;
        gcyc = cyc;
      end
      step();
    end
    req[id] = 1'b0;
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL gnt_timeout: got no gnt[%0d] within 40 cycles, required one", id);
    end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!ctrl_busy) done = 1'b1;
      step();
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: got ctrl_busy=1 for 100 cycles, required 0");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", W'({gnt, rsp_valid, rsp_rdata, rsp_err, ctrl_busy, wr_en,
                               wr_addr, wr_data, rd_addr_a}), '0);
    step();
  endtask

  task automatic do_read(input int id, input logic [2:0] addr, input logic [15:0] exp_d);
    int g;
    issue(id, 1'b0, addr, 16'h0000, g);
    exp_rsp_q.push_back(rsp_vec(g + 3, id, 2'd0, exp_d));
    wait_idle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, g, g0, g1;

    // Read of BAUD after reset: grant same cycle, rd_addr_a next cycle, response at +3.
    do_reset();
    r = cyc;
    issue(0, 1'b0, 3'(ADDR_BAUD), 16'h0000, g);
    check("read_gnt_cycle", W'(g - r), '0);
    exp_rsp_q.push_back(rsp_vec(g + 3, 0, 2'd0, 16'd9600));
    @(negedge clk);
    check("read_rd_addr", W'(rd_addr_a), W'(1));
    step();
    wait_idle();

    // Simultaneous CTRL writes: requester 0 first, requester 1 three cycles later.
    do_reset();
    r = cyc;
    fork
      begin
        issue(0, 1'b1, 3'(ADDR_CTRL), 16'h000B, g0);
        exp_wr_q.push_back(wr_vec(g0 + 1, 3'(ADDR_CTRL), 16'h000B));
        exp_rsp_q.push_back(rsp_vec(g0 + 2, 0, 2'd0, 16'h0000));
      end
      begin
        issue(1, 1'b1, 3'(ADDR_CTRL), 16'h0005, g1);
        exp_wr_q.push_back(wr_vec(g1 + 1, 3'(ADDR_CTRL), 16'h0005));
        exp_rsp_q.push_back(rsp_vec(g1 + 2, 1, 2'd0, 16'h0000));
      end
    join
    check("rr_first_gnt", W'(g0 - r), '0);
    check("rr_second_gnt", W'(g1 - g0), W'(3));
    wait_idle();
    do_read(0, 3'(ADDR_CTRL), 16'h0005);

    // BAUD write deferred by uart_busy, then committed by update_ok.
    uart_busy = 1'b1;
    issue(1, 1'b1, 3'(ADDR_BAUD), 16'd4800, g);
    exp_wr_q.push_back(wr_vec(g + 11, 3'(ADDR_BAUD), 16'd4800));
    exp_rsp_q.push_back(rsp_vec(g + 17, 1, 2'd0, 16'h0000));
    wait_until(g + 10);
    uart_busy = 1'b0;
    wait_until(g + 16);
    update_ok = 1'b1;
    step();
    update_ok = 1'b0;
    wait_idle();
    do_read(0, 3'(ADDR_BAUD), 16'd4800);

    // BAUD write with no commit: timeout response 16 cycles after wr_en.
    issue(0, 1'b1, 3'(ADDR_BAUD), 16'd1200, g);
    exp_wr_q.push_back(wr_vec(g + 1, 3'(ADDR_BAUD), 16'd1200));
    exp_rsp_q.push_back(rsp_vec(g + 17, 0, 2'd2, 16'h0000));
    wait_until(g + 17);
    @(negedge clk);
    check("timeout_busy_in_rsp", W'(ctrl_busy), W'(1));
    step();
    @(negedge clk);
    check("timeout_busy_after_rsp", W'(ctrl_busy), '0);
    step();

    // Out-of-range write and read: immediate error, no register-file activity.
    r = wr_cnt;
    issue(0, 1'b1, 3'd6, 16'hDEAD, g);
    exp_rsp_q.push_back(rsp_vec(g + 1, 0, 2'd1, 16'h0000));
    wait_idle();
    issue(1, 1'b0, 3'd5, 16'h0000, g);
    exp_rsp_q.push_back(rsp_vec(g + 1, 1, 2'd1, 16'h0000));
    wait_idle();
    @(negedge clk);
    check("oob_rd_addr_held", W'(rd_addr_a), W'(1));
    check("oob_no_write", W'(wr_cnt - r), '0);
    step();

    // Reset during BAUD_WAIT aborts silently; a fresh request is granted at once.
    issue(1, 1'b1, 3'(ADDR_BAUD), 16'h0007, g);
    exp_wr_q.push_back(wr_vec(g + 1, 3'(ADDR_BAUD), 16'h0007));
    wait_until(g + 4);
    rst = 1'b1;
    wait_until(g + 5);
    rst = 1'b0;
    @(negedge clk);
    check("abort_outputs", W'({gnt, rsp_valid, rsp_rdata, rsp_err, ctrl_busy, wr_en,
                               wr_addr, wr_data, rd_addr_a}), '0);
    step();
    r = cyc;
    issue(1, 1'b0, 3'(ADDR_STATUS), 16'h0000, g);
    check("abort_regrant", W'(g - r), '0);
    exp_rsp_q.push_back(rsp_vec(g + 3, 1, 2'd0, 16'h00A5));
    wait_idle();

    repeat (5) step();
    check("rsp_q_drained", W'(exp_rsp_q.size()), '0);
    check("wr_q_drained", W'(exp_wr_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cfg_arbiter.md
Name: uart_cfg_arbiter

Overview:
- Sits between two configuration masters (requester 0 = host bus, requester 1 = boot/config sequencer) and the UART register file.
- Owns the register-file write port and read port A.
- Arbitrates round-robin, one transaction in flight.
- Sequences BAUD updates: defers a BAUD write while the UART is busy, then waits for the update_ok commit handshake with a timeout.
- Rejects out-of-range addresses without touching the register file.

Parameters:
- DATA_WIDTH, 16, register data width.
- ADDR_WIDTH, 3, register address width (matches register-file wr_addr/rd_addr).
- N_REG, 4, number of implemented registers; addr >= N_REG is out of bounds (OOB).
- BAUD_ADDR, 1, address of the shadowed BAUD register.
- READ_LATENCY, 1, register-file read latency in cycles (>= 1).
- TIMEOUT_CYC, 1024, maximum wait cycles for busy-clear or update_ok.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  2  per-requester request; held until gnt.
- req_we  in  2  per-requester 1 = write, 0 = read.
- req_addr  in  2*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  2*DATA_WIDTH  packed write data.
- gnt  out  2  one-hot, one-cycle acceptance pulse.
- rsp_valid  out  2  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  2  0 = OK, 1 = OOB, 2 = TIMEOUT.
- ctrl_busy  out  1  high whenever state != IDLE.
- wr_en  out  1  register-file write enable.
- wr_addr  out  ADDR_WIDTH  register-file write address.
- wr_data  out  DATA_WIDTH  register-file write data.
- rd_addr_a  out  ADDR_WIDTH  register-file read address, port A.
- rd_data_a  in  DATA_WIDTH  register-file read data, port A.
- uart_busy  in  1  UART busy status.
- update_ok  in  1  UART commit pulse for the BAUD shadow.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr = 0 (requester 0 favoured); counters 0.
- Reset mid-transaction: abort; no rsp_valid is issued; wr_en is forced 0 in the cycle after reset is sampled.
- Registered outputs: all except gnt.
- gnt is combinational, IDLE only: if both req are high, grant rr_ptr; otherwise grant the single requester.
- Capture: on the granting edge, latch the we/addr/wdata fields and the winner id.
- rr_ptr update: in RSP, rr_ptr <= ~winner.

State transitions out of IDLE (cycle 0 = grant cycle):
- addr >= N_REG -> RSP with err = 1. No wr_en and no rd_addr_a change; rsp_valid at cycle 1.
- Read -> RD. rd_addr_a is driven from cycle 1 and held; a counter runs READ_LATENCY cycles; rd_data_a is captured at cycle 1+READ_LATENCY; rsp_valid at cycle 2+READ_LATENCY.
- Write, non-BAUD -> WR. wr_en is high for exactly cycle 1; rsp_valid at cycle 2.
- Write to BAUD, uart_busy = 0 -> WR.
- Write to BAUD, uart_busy = 1 -> HOLD.

Other states:
- HOLD: counts cycles. Move to WR on the first cycle uart_busy = 0. If the count reaches TIMEOUT_CYC, go to RSP with err = 2; no write is issued.
- WR (BAUD): single wr_en pulse, then BAUD_WAIT with the counter cleared.
- BAUD_WAIT: update_ok is sampled from the cycle after wr_en (a pulse coincident with wr_en is ignored). On update_ok -> RSP, err = 0. On TIMEOUT_CYC cycles -> RSP, err = 2.
- RSP: one-cycle rsp_valid[winner], then IDLE. gnt stays low in RSP, so the minimum request spacing is 3 cycles.

Boundaries:
- TIMEOUT_CYC counter width is $clog2(TIMEOUT_CYC+1); no wrap is possible because the counter stops at terminal count.
- wr_addr/wr_data hold their last values when wr_en = 0.
- rsp_rdata is cleared to 0 on any non-read response.
- A requester deasserting req before gnt is legal; no grant is issued to it.

Decomposition:
- Package uart_cfg_pkg:
  - enum cfg_state_e {IDLE, RD, WR, HOLD, BAUD_WAIT, RSP}
  - enum rsp_err_e {ERR_OK = 0, ERR_OOB = 1, ERR_TIMEOUT = 2}
  - register address constants ADDR_CTRL = 0, ADDR_BAUD = 1, ADDR_STATUS = 2
  - BAUD reset constant 9600
- Sub-module rr_arb2: a 2-requester round-robin arbiter holding rr_ptr and producing gnt; the FSM and datapath stay in the top.

Test Plan:
- Reset, then req0 reads addr 1 (register file holds 9600) -> gnt[0] at cycle 0, rd_addr_a = 1 at cycle 1, rsp_valid[0] at cycle 3 with rsp_rdata = 9600, rsp_err = 0.
- Both requesters write CTRL in the same cycle: req0 data 0x000B, req1 data 0x0005 -> req0 granted first, wr_en pulse with 0x000B, then req1 granted, wr_en with 0x0005; readback of addr 0 = 0x0005.
- req1 writes BAUD = 4800 with uart_busy = 1 for 10 cycles -> no wr_en during the busy window; wr_en one cycle after busy drops; update_ok pulsed 5 cycles later -> rsp_valid[1] with err = 0; readback of addr 1 = 4800.
- BAUD write, update_ok never asserted, TIMEOUT_CYC = 16 -> rsp_err = 2 exactly 16 cycles after wr_en; ctrl_busy drops the cycle after rsp.
- Write addr 6, then read addr 5 (N_REG = 4) -> rsp_err = 1 at cycle 1; wr_en never asserted; rd_addr_a unchanged.
- Assert rst during BAUD_WAIT -> no rsp_valid; all outputs 0 the next cycle; a following req1-only request is granted immediately.
